// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, derived totals, sync windows and the coordinate type
// used by the sync generator and the downstream renderer.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam bit          SYNC_ACTIVE = 1'b0;

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows are half-open: START <= cnt < END.
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_window(coord_t c, int unsigned lo, int unsigned hi);
    int unsigned cv = 32'(c);
    return (cv >= lo) && (cv < hi);
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Clock-enable divider: one registered pulse every CLK_DIV system clocks.
module vga_pix_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  if (CLK_DIV < 1) begin : g_bad_div
    $fatal(1, "vga_pix_tick: CLK_DIV must be at least 1");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_MAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan-position and sync generator; all decodes are registered alongside the
// counters so they always match the presented pixel_x/pixel_y.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP        = vga_pkg::H_FP,
  parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
  parameter int unsigned H_BP        = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP        = vga_pkg::V_FP,
  parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
  parameter int unsigned V_BP        = vga_pkg::V_BP,
  parameter bit          SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  output logic                        o_pixel_tick,
  output logic [vga_pkg::COORD_W-1:0] o_pixel_x,
  output logic [vga_pkg::COORD_W-1:0] o_pixel_y,
  output logic                        o_hsync,
  output logic                        o_vsync,
  output logic                        o_video_on,
  output logic                        o_line_start,
  output logic                        o_frame_start
);

  import vga_pkg::*;

  localparam int unsigned L_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned L_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned L_HS_START = H_ACTIVE + H_FP;
  localparam int unsigned L_HS_END   = L_HS_START + H_SYNC;
  localparam int unsigned L_VS_START = V_ACTIVE + V_FP;
  localparam int unsigned L_VS_END   = L_VS_START + V_SYNC;

  if ((L_H_TOTAL > 1024) || (L_V_TOTAL > 1024)) begin : g_bad_timing
    $fatal(1, "vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam coord_t L_H_MAX = coord_t'(L_H_TOTAL - 1);
  localparam coord_t L_V_MAX = coord_t'(L_V_TOTAL - 1);

  logic   w_tick;
  logic   w_h_wrap;
  logic   w_v_wrap;
  coord_t w_h_nxt;
  coord_t w_v_nxt;

  coord_t r_h_cnt;
  coord_t r_v_cnt;
  logic   r_hsync;
  logic   r_vsync;
  logic   r_video_on;
  logic   r_line_start;
  logic   r_frame_start;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_h_wrap = (r_h_cnt == L_H_MAX);
    w_v_wrap = (r_v_cnt == L_V_MAX);
    w_h_nxt  = w_h_wrap ? '0 : r_h_cnt + 1'b1;
    w_v_nxt  = r_v_cnt;
    if (w_h_wrap) begin
      w_v_nxt = w_v_wrap ? '0 : r_v_cnt + 1'b1;
    end
  end

  // Reset parks the scan at the last pixel so the first tick lands on (0,0).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt       <= L_H_MAX;
      r_v_cnt       <= L_V_MAX;
      r_hsync       <= ~SYNC_ACTIVE;
      r_vsync       <= ~SYNC_ACTIVE;
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_tick) begin
      r_h_cnt       <= w_h_nxt;
      r_v_cnt       <= w_v_nxt;
      r_hsync       <= in_window(w_h_nxt, L_HS_START, L_HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync       <= in_window(w_v_nxt, L_VS_START, L_VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_video_on    <= (32'(w_h_nxt) < H_ACTIVE) && (32'(w_v_nxt) < V_ACTIVE);
      r_line_start  <= (w_h_nxt == '0);
      r_frame_start <= (w_h_nxt == '0) && (w_v_nxt == '0);
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign o_pixel_tick  = w_tick;
  assign o_pixel_x     = r_h_cnt;
  assign o_pixel_y     = r_v_cnt;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_video_on    = r_video_on;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Upstream timing stage for the VGA overlay renderer.
- Generates the pixel scan position (pixel_x, pixel_y), horizontal and vertical sync, active-video flag and frame/line markers from the system clock.
- The renderer consumes pixel_x and pixel_y directly.
- Default timing is 640x480@60 Hz from a 50 MHz clock, using a divide-by-2 pixel clock-enable; no second clock domain.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=1)
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, logic level of an asserted hsync/vsync

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- pixel_tick  out  1  one-clk pulse every CLK_DIV clocks; pixel clock-enable
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level SYNC_ACTIVE when asserted
- vsync  out  1  vertical sync, level SYNC_ACTIVE when asserted
- video_on  out  1  high while (pixel_x, pixel_y) is in the visible area
- line_start  out  1  one-clk pulse when pixel_x becomes 0
- frame_start  out  1  one-clk pulse when (pixel_x, pixel_y) becomes (0,0)

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).

Divider:
- div_cnt counts 0..CLK_DIV-1 and wraps.
- pixel_tick is registered and is high for exactly one clk when div_cnt wraps.
- With CLK_DIV=1, pixel_tick is constantly high after the first clk out of reset.

Counters:
- Counters advance only in the cycle where pixel_tick is high.
- h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
- v_cnt wraps from V_TOTAL-1 to 0 when h_cnt also wraps.
- pixel_x and pixel_y are the counter registers themselves; they change one clk after the pixel_tick pulse.

Decodes (registered, updated in the same cycle as the counters, so always consistent with the presented pixel_x/pixel_y):
- hsync asserted iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- vsync asserted iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- line_start is high for one clk when h_cnt has just become 0; low otherwise, including on non-tick cycles.
- frame_start is high for one clk when both counters have just become 0.

Reset (asynchronous assert, synchronous release on next clk):
- div_cnt=0, pixel_x=H_TOTAL-1 (799), pixel_y=V_TOTAL-1 (524).
- hsync=vsync=!SYNC_ACTIVE, video_on=0, pixel_tick=0, line_start=0, frame_start=0.
- The first tick after release wraps to (0,0) and pulses frame_start and line_start, so the first output frame is complete.
- Reset asserted mid-line or mid-frame returns all outputs to these values immediately (asynchronously), with no partial-pulse glitch beyond the asynchronous clear.

Widths and latency:
- 10-bit counters are sufficient for the defaults; width is fixed at 10 to match the renderer.
- A parameter set with H_TOTAL or V_TOTAL > 1024 is illegal; flag it with an elaboration-time assertion.
- Latency from clk edge to new position is 1 clk. No handshake: the downstream consumer samples every clk and must tolerate a position held for CLK_DIV clocks.

Decomposition:
- Shared package vga_pkg holds:
  - the timing defaults (H_ACTIVE..V_BP, SYNC_ACTIVE);
  - the derived H_TOTAL and V_TOTAL;
  - the constants HS_START/HS_END and VS_START/VS_END;
  - a typedef for the 10-bit coordinate, shared by vga_sync_gen and vga_proc.
- One sub-module, vga_pix_tick, is natural: the CLK_DIV clock-enable divider with async active-low reset, reusable by other pixel-rate blocks.

Test Plan:
- Reset release, defaults: first pixel_tick at clk 2 -> pixel_x=0, pixel_y=0, video_on=1, frame_start=1 and line_start=1 for one clk; hsync=vsync=1.
- Run one line: pixel_x steps 0..799 every 2 clks.
  - video_on falls when pixel_x=640.
  - hsync=0 exactly for pixel_x 656..751 (192 clks).
  - After 799, pixel_x=0, pixel_y=1, line_start=1.
- Run one full frame (800*525*2 = 840000 clks):
  - vsync=0 exactly for pixel_y 490..491 (3200 clks).
  - frame_start pulses once per frame, 840000 clks apart.
  - 307200 clk-ticks have video_on=1.
- Wrap corner: at (799,524) the next tick -> (0,0), frame_start=1, vsync deasserted, video_on=1 on the same clk.
- Assert reset at pixel (300,200) mid-tick-period -> immediately pixel_x=799, pixel_y=524, video_on=0, hsync=vsync=1; after release the sequence restarts identically to the first scenario.
- CLK_DIV=1, SYNC_ACTIVE=1 -> pixel_tick high every clk after the first; hsync=1 for pixel_x 656..751 (96 clks); idle sync level 0.
